// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty control path.
//   PWM_DUTY_W   : default duty code width (matches the pwm core sw input)
//   PWM_DUTY_MAX : largest code representable at the default width
//   ramp_state_t : slew FSM states
package pwm_pkg;

  localparam int unsigned PWM_DUTY_W   = 4;
  localparam int unsigned PWM_DUTY_MAX = (1 << PWM_DUTY_W) - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    RAMP_DN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, consecutive-mismatch counter and
// press pulse generator.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   btn   : raw asynchronous button, active-high
//   press : one-cycle pulse when the debounced level rises (release is silent)
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This sample is the DEB_CYCLES-th consecutive disagreement.
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Upstream stage of the PWM generator: debounced up/down buttons and a load
// strobe set a saturating target duty; the output duty slews toward the target
// one LSB every RAMP_DIV cycles.
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   btn_up   : raw button, increments target
//   btn_dn   : raw button, decrements target
//   load     : one-cycle strobe, target <= load_val
//   load_val : value captured on load
//   duty_o   : current duty code for the pwm core
//   busy     : high while the slew FSM is not IDLE
//   at_max   : target is the full-scale code
//   at_min   : target is zero
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned       DUTY_W     = PWM_DUTY_W,
  parameter int unsigned       DEB_CYCLES = 16,
  parameter int unsigned       RAMP_DIV   = 256,
  parameter logic [DUTY_W-1:0] DUTY_RST   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_up,
  input  logic              btn_dn,
  input  logic              load,
  input  logic [DUTY_W-1:0] load_val,
  output logic [DUTY_W-1:0] duty_o,
  output logic              busy,
  output logic              at_max,
  output logic              at_min
);

  localparam int unsigned      DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  logic              up_press;
  logic              dn_press;
  logic [DUTY_W-1:0] target;
  logic [DIV_W-1:0]  div;
  ramp_state_t       state;
  ramp_state_t       next_state;
  logic              div_clr;
  logic              step;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_up),
    .press (up_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_dn),
    .press (dn_press)
  );

  // Target register: load beats buttons; opposing presses cancel; saturate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target <= DUTY_RST;
    end else if (load) begin
      target <= load_val;
    end else if (up_press && dn_press) begin
      target <= target;
    end else if (up_press) begin
      if (target != '1) target <= target + 1'b1;
    end else if (dn_press) begin
      if (target != '0) target <= target - 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state follows the current target/duty relation every cycle.
  always_comb begin
    next_state = IDLE;
    if (target > duty_o)      next_state = RAMP_UP;
    else if (target < duty_o) next_state = RAMP_DN;
  end

  // FSM outputs. A step needs the direction to persist; entering a ramp,
  // reversing, or reaching target restarts the divider instead, so a
  // reversal never produces a step in the stale direction.
  always_comb begin
    busy    = (state != IDLE);
    at_max  = (target == '1);
    at_min  = (target == '0);
    div_clr = (next_state != state) || (next_state == IDLE);
    step    = !div_clr && (div == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div    <= '0;
      duty_o <= DUTY_RST;
    end else begin
      if (div_clr || step) div <= '0;
      else                 div <= div + 1'b1;
      if (step) begin
        if (state == RAMP_UP) duty_o <= duty_o + 1'b1;
        else                  duty_o <= duty_o - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl with DEB_CYCLES=4, RAMP_DIV=3,
// DUTY_RST=0: directed scenarios plus a randomized phase, all compared each
// cycle against a behavioural model.
module tb_pwm_duty_ctrl;
  import pwm_pkg::*;

  localparam int DEB  = 4;
  localparam int DIV  = 3;
  localparam int DMAX = PWM_DUTY_MAX;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] duty_o;
  logic       busy;
  logic       at_max;
  logic       at_min;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  pwm_duty_ctrl #(
    .DUTY_W     (4),
    .DEB_CYCLES (DEB),
    .RAMP_DIV   (DIV),
    .DUTY_RST   (4'd0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .load     (load),
    .load_val (load_val),
    .duty_o   (duty_o),
    .busy     (busy),
    .at_max   (at_max),
    .at_min   (at_min)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model. Raw buttons reach the debouncer two edges late; a level
  // is accepted once DEB consecutive late samples disagree with it. Ramp steps
  // land every DIV edges counted from the edge where the direction began.
  int m_cyc = 0;
  int m_tgt = 0;
  int m_duty = 0;
  int m_dir = 0;
  int m_start = 0;
  int m_h0[2];
  int m_h1[2];
  int m_lvl[2];
  int m_run[2];
  int m_pend[2];
  int raw[2];
  int samp;
  int d;
  int n_tgt;
  int n_duty;

  always @(posedge clk) begin
    m_cyc++;
    raw[0] = int'(btn_up);
    raw[1] = int'(btn_dn);
    if (!rst_n) begin
      m_tgt = 0;
      m_duty = 0;
      m_dir = 0;
      m_start = m_cyc;
      for (int b = 0; b < 2; b++) begin
        m_h0[b] = 0; m_h1[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_pend[b] = 0;
      end
    end else begin
      d = (m_tgt > m_duty) ? 1 : ((m_tgt < m_duty) ? -1 : 0);
      n_duty = m_duty;
      if (d == 0) begin
        m_dir = 0;
      end else if (d != m_dir) begin
        m_dir = d;
        m_start = m_cyc;
      end else if (((m_cyc - m_start) % DIV) == 0) begin
        n_duty = m_duty + d;
      end

      n_tgt = m_tgt;
      if (load)                         n_tgt = int'(load_val);
      else if (m_pend[0] && m_pend[1])  n_tgt = m_tgt;
      else if (m_pend[0])               n_tgt = (m_tgt < DMAX) ? m_tgt + 1 : DMAX;
      else if (m_pend[1])               n_tgt = (m_tgt > 0) ? m_tgt - 1 : 0;

      for (int b = 0; b < 2; b++) begin
        samp = m_h1[b];
        m_h1[b] = m_h0[b];
        m_h0[b] = raw[b];
        m_pend[b] = 0;
        if (samp == m_lvl[b]) m_run[b] = 0;
        else                  m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = samp;
          m_run[b] = 0;
          m_pend[b] = samp;
        end
      end
      m_tgt = n_tgt;
      m_duty = n_duty;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("duty", int'(duty_o), m_duty);
      check("busy", int'(busy), int'(m_dir != 0));
      check("at_max", int'(at_max), int'(m_tgt == DMAX));
      check("at_min", int'(at_min), int'(m_tgt == 0));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k;
    k = 0;
    cycles(2);
    while (busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    load_val = 4'(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic press(input bit up, input bit dn, input int hold);
    btn_up = up;
    btn_dn = dn;
    cycles(hold);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    cycles(DEB + 4);
  endtask

  task automatic wait_duty(input string tag, input int v, input int lim);
    int k;
    k = 0;
    while (int'(duty_o) != v && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(tag, int'(duty_o), v);
  endtask

  initial begin
    int k;
    int r;
    // 1: reset and idle
    rst_n = 1'b0;
    cycles(2);
    check("rst_duty", int'(duty_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_min", int'(at_min), 1);
    check("rst_max", int'(at_max), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cycles(20);
    check("idle_duty", int'(duty_o), 0);
    check("idle_busy", int'(busy), 0);

    // 2: short glitch ignored, long hold accepted
    press(1'b1, 1'b0, 2);
    cycles(5);
    check("glitch_duty", int'(duty_o), 0);
    check("glitch_min", int'(at_min), 1);
    btn_up = 1'b1;
    k = 0;
    while (!busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t2_busy_rise", int'(busy), 1);
    k = 0;
    while (int'(duty_o) != 1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t2_ramp_latency", k, 3);
    cycles(2);
    btn_up = 1'b0;
    wait_idle("t2", 20);
    check("t2_duty", int'(duty_o), 1);
    cycles(DEB + 4);

    // 3: full-scale load, step spacing, saturation at max
    do_load(15);
    wait_duty("t3_first", 2, 20);
    for (int s = 3; s <= 15; s++) begin
      k = 0;
      while (int'(duty_o) != s && k < 10) begin
        @(negedge clk);
        k++;
      end
      check("t3_spacing", k, 3);
    end
    wait_idle("t3", 10);
    check("t3_duty", int'(duty_o), 15);
    check("t3_max", int'(at_max), 1);
    press(1'b1, 1'b0, 8);
    cycles(5);
    check("t3_sat_duty", int'(duty_o), 15);
    check("t3_sat_busy", int'(busy), 0);

    // 4: reversal mid-ramp
    do_load(0);
    wait_idle("t4a", 80);
    check("t4_zero", int'(duty_o), 0);
    do_load(12);
    wait_duty("t4_reach5", 5, 40);
    load = 1'b1;
    load_val = 4'd3;
    @(negedge clk);
    load = 1'b0;
    cycles(3);
    check("t4_no_early_step", int'(duty_o), 5);
    check("t4_busy", int'(busy), 1);
    cycles(1);
    check("t4_step4", int'(duty_o), 4);
    cycles(3);
    check("t4_step3", int'(duty_o), 3);
    wait_idle("t4", 10);
    check("t4_final", int'(duty_o), 3);

    // 5: opposing presses cancel; load beats a coincident up pulse
    press(1'b1, 1'b1, 8);
    cycles(4);
    check("t5_both_duty", int'(duty_o), 3);
    check("t5_both_busy", int'(busy), 0);
    btn_up = 1'b1;
    cycles(6);
    load = 1'b1;
    load_val = 4'd9;
    @(negedge clk);
    load = 1'b0;
    cycles(4);
    btn_up = 1'b0;
    wait_idle("t5", 60);
    check("t5_load_wins", int'(duty_o), 9);
    cycles(DEB + 4);

    // 6: reset mid-ramp, then down press at zero
    do_load(0);
    wait_duty("t6_reach7", 7, 30);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_rst_duty", int'(duty_o), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_min", int'(at_min), 1);
    press(1'b0, 1'b1, 8);
    cycles(4);
    check("t6_dn_duty", int'(duty_o), 0);
    check("t6_dn_min", int'(at_min), 1);

    // Randomized phase, checked cycle by cycle against the model.
    repeat (150) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        btn_up = 1'($urandom_range(0, 1));
        btn_dn = 1'($urandom_range(0, 1));
        cycles(int'($urandom_range(1, 12)));
      end else if (r <= 5) begin
        do_load(int'($urandom_range(0, 15)));
      end else if (r == 6) begin
        btn_up = ~btn_up;
        cycles(int'($urandom_range(1, 3)));
        btn_up = ~btn_up;
      end else if (r == 7) begin
        cycles(int'($urandom_range(1, 20)));
      end else if (r == 8 && $urandom_range(0, 3) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cycles(int'($urandom_range(1, 8)));
      end
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    cycles(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
